// File: rtl/mdu_pkg.sv
// Shared encodings and sizing constants for the multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6,
    MDU_RSVD  = 3'd7
  } mdu_op_e;

  localparam int CNT_W              = 4;
  localparam int MULT_CYCLES_DEFAULT = 5;
  localparam int DIV_CYCLES_DEFAULT  = 10;

endpackage : mdu_pkg

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit: fixed-latency mult/div into architectural HI/LO,
// plus single-cycle mthi/mtlo writes.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

  logic [CNT_W-1:0] count;
  logic [63:0]      pending;   // {hi, lo} to publish when the count expires
  logic [63:0]      result;
  logic signed [63:0] prod_s;
  logic [63:0]      prod_u;
  logic signed [31:0] quot_s, rem_s;
  logic [31:0]      quot_u, rem_u;
  logic             accept;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'b0, a} * {32'b0, b};
  assign quot_s = $signed(a) / $signed(b);
  assign rem_s  = $signed(a) % $signed(b);
  assign quot_u = a / b;
  assign rem_u  = a % b;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    result = '0;
    case (op)
      MDU_MULT:  result = prod_s;
      MDU_MULTU: result = prod_u;
      MDU_DIV: begin
        if (b == '0)
          result = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          result = {32'h0, 32'h8000_0000};
        else
          result = {rem_s, quot_s};
      end
      MDU_DIVU: begin
        if (b == '0)
          result = {a, 32'hFFFF_FFFF};
        else
          result = {rem_u, quot_u};
      end
      default: result = '0;
    endcase
  end

  assign busy   = (count != '0);
  assign accept = start && !flush && !busy;

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      pending <= '0;
      hi      <= '0;
      lo      <= '0;
    end else if (busy) begin
      count <= count - 1'b1;
      if (count == CNT_W'(1)) {hi, lo} <= pending;
    end else if (accept) begin
      case (op)
        MDU_MULT, MDU_MULTU: begin
          pending <= result;
          count   <= MULT_N;
        end
        MDU_DIV, MDU_DIVU: begin
          pending <= result;
          count   <= DIV_N;
        end
        MDU_MTHI: hi <= a;
        MDU_MTLO: lo <= a;
        default: ;
      endcase
    end
  end

endmodule : mdu_unit

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed cases from the test plan plus a
// randomized sequence checked against a plain-arithmetic reference model.
module tb_mdu_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        flush;
  logic        busy;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;
  logic [31:0] m_hi, m_lo;   // reference HI/LO

  mdu_unit dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .flush(flush),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Architectural result {hi, lo} computed with 64-bit integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy, sq, sr;
    longint unsigned ux, uy, uq, ur;
    logic [63:0]     r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = 64'(x);
    uy = 64'(y);
    r  = '0;
    case (o)
      3'd1: r = 64'(sx * sy);
      3'd2: r = ux * uy;
      3'd3: if (y == 0) r = {x, 32'hFFFF_FFFF};
            else begin
              sq = sx / sy;
              sr = sx % sy;
              r  = {sr[31:0], sq[31:0]};
            end
      3'd4: if (y == 0) r = {x, 32'hFFFF_FFFF};
            else begin
              uq = ux / uy;
              ur = ux % uy;
              r  = {ur[31:0], uq[31:0]};
            end
      default: r = '0;
    endcase
    return r;
  endfunction

  // One-cycle start pulse; returns at the negedge after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
  endtask

  // Counts busy cycles from the current negedge (already_seen counted before), checking
  // HI/LO hold their old values; then checks latency and final result.
  task automatic finish_long(input string tag, input logic [2:0] o, input logic [31:0] x,
                             input logic [31:0] y, input int already_seen);
    int n;
    logic [63:0] r;
    n = already_seen;
    while (busy === 1'b1 && n < 40) begin
      check({tag, " hold"}, {hi, lo}, {m_hi, m_lo});
      n++;
      @(negedge clk);
    end
    check({tag, " busy_cycles"}, 64'(n), (o == 3'd1 || o == 3'd2) ? 64'd5 : 64'd10);
    r = ref_result(o, x, y);
    {m_hi, m_lo} = r;
    check({tag, " result"}, {hi, lo}, r);
  endtask

  task automatic do_long(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    issue(o, x, y);
    finish_long(tag, o, x, y, 0);
  endtask

  task automatic do_move(input string tag, input logic [2:0] o, input logic [31:0] x);
    issue(o, x, 32'h0);
    if (o == 3'd5) m_hi = x; else m_lo = x;
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " hilo"}, {hi, lo}, {m_hi, m_lo});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0; flush = 1'b0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset busy", 64'(busy), 64'd0);
    check("reset hilo", {hi, lo}, 64'd0);

    // Directed arithmetic cases
    do_long("mult -1*2", MDU_MULT, 32'hFFFF_FFFF, 32'h2);
    check("mult const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
    do_long("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'h2);
    check("multu const", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
    do_long("div -7/2", MDU_DIV, 32'hFFFF_FFF9, 32'h2);
    check("div const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_long("divu 7/2", MDU_DIVU, 32'h7, 32'h2);
    check("divu const", {hi, lo}, 64'h0000_0001_0000_0003);
    do_long("divu by0", MDU_DIVU, 32'h1234_5678, 32'h0);
    check("divu by0 const", {hi, lo}, 64'h1234_5678_FFFF_FFFF);
    do_long("div ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div ovf const", {hi, lo}, 64'h0000_0000_8000_0000);
    do_long("div by0", MDU_DIV, 32'h8765_4321, 32'h0);

    // Moves
    do_move("mthi", MDU_MTHI, 32'hDEAD_BEEF);
    do_move("mtlo", MDU_MTLO, 32'h0000_CAFE);
    check("moves const", {hi, lo}, 64'hDEAD_BEEF_0000_CAFE);

    // No-op encodings
    issue(MDU_NONE, 32'h1111_1111, 32'h2);
    check("op0 busy", 64'(busy), 64'd0);
    check("op0 hilo", {hi, lo}, {m_hi, m_lo});
    issue(MDU_RSVD, 32'h1111_1111, 32'h2);
    check("op7 busy", 64'(busy), 64'd0);
    check("op7 hilo", {hi, lo}, {m_hi, m_lo});

    // Starts while busy are ignored
    issue(MDU_MULT, 32'h0001_0000, 32'hFFFF_0003);
    start = 1'b1; op = MDU_DIV; a = 32'h64; b = 32'h3;
    @(negedge clk);
    op = MDU_MTHI; a = 32'h5555_AAAA;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    finish_long("mult ignore", MDU_MULT, 32'h0001_0000, 32'hFFFF_0003, 2);

    // Flushed starts are ignored
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = MDU_MULT; a = 32'h3; b = 32'h4;
    @(negedge clk);
    check("flush mult busy", 64'(busy), 64'd0);
    op = MDU_MTLO; a = 32'h9999_9999;
    @(negedge clk);
    start = 1'b0; flush = 1'b0; op = 3'd0;
    check("flush busy", 64'(busy), 64'd0);
    check("flush hilo", {hi, lo}, {m_hi, m_lo});

    // Reset during the third busy cycle of a divide
    issue(MDU_DIV, 32'h0000_1000, 32'h7);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset hilo", {hi, lo}, 64'd0);
    repeat (15) @(negedge clk);
    check("midreset later", {hi, lo}, 64'd0);

    // Randomized back-to-back sequence
    for (int i = 0; i < 24; i++) begin
      logic [2:0]  o;
      logic [31:0] x, y;
      o = 3'($urandom_range(1, 6));
      x = $urandom;
      y = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 3) == 0) y = y >> $urandom_range(0, 31);
      if (o == 3'd5 || o == 3'd6) do_move("rand move", o, x);
      else do_long("rand long", o, x, y);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule : tb_mdu_unit
